// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch front-end.
package fetch_queue_pkg;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] word_t;

    // Fetch never issues from this address; it is also the idle lookup address.
    localparam addr_t NULL_PTR = 32'hFFFF_FFFC;
    localparam int unsigned INST_BYTES = 4;
    localparam word_t ZERO = '0;

    // One FIFO entry: an instruction and the PC it was fetched from.
    typedef struct packed {
        addr_t pc;
        word_t inst;
    } fq_entry_t;

    // Advance a PC by n instructions, wrapping at 2^32.
    function automatic addr_t advance(input addr_t pc, input logic [1:0] n);
        return pc + addr_t'(n) * addr_t'(INST_BYTES);
    endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Cache lookup pair and decode-side queue signals of the fetch front-end.
interface fetch_queue_if;
    import fetch_queue_pkg::*;

    logic  en_rx;
    addr_t pcx;
    logic  hitx;
    word_t instx;
    logic  en_ry;
    addr_t pcy;
    logic  hity;
    word_t insty;
    logic  q_pop;
    logic  q_valid;
    word_t q_inst;
    addr_t q_pc;

    modport master (
        output en_rx, pcx, en_ry, pcy, q_valid, q_inst, q_pc,
        input  hitx, instx, hity, insty, q_pop
    );

    modport slave (
        input  en_rx, pcx, en_ry, pcy, q_valid, q_inst, q_pc,
        output hitx, instx, hity, insty, q_pop
    );

endinterface

// File: rtl/fetch_queue_inst_fifo.sv
// Instruction FIFO: up to two pushes and one pop per cycle, synchronous clear.
// push1 is only meaningful together with push0 (din1 lands after din0).
module inst_fifo
    import fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    localparam int unsigned AW = $clog2(DEPTH)
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      en,
    input  logic      clr,
    input  logic      push0,
    input  logic      push1,
    input  fq_entry_t din0,
    input  fq_entry_t din1,
    input  logic      pop,
    output logic      valid,
    output fq_entry_t head,
    output logic [AW:0] count
);

    logic [AW-1:0] rd;
    logic [AW-1:0] wr;
    logic [AW:0]   cnt;
    logic [AW:0]   npush;
    logic [AW:0]   npop;
    fq_entry_t     mem [DEPTH];

    // Number of entries entering and leaving this cycle; pop on empty is dropped.
    always_comb begin
        npush = (AW+1)'(push0) + (AW+1)'(push1);
        npop  = (AW+1)'(pop && (cnt != '0));
    end

    // Pointer and occupancy update; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            rd  <= '0;
            wr  <= '0;
            cnt <= '0;
        end else if (en) begin
            wr  <= wr + AW'(npush);
            rd  <= rd + AW'(npop);
            cnt <= cnt + npush - npop;
        end
    end

    // Entry storage; not reset, contents are qualified by cnt.
    always_ff @(posedge clk) begin
        if (!rst && !clr && en) begin
            if (push0) mem[wr] <= din0;
            if (push1) mem[wr + AW'(1)] <= din1;
        end
    end

    // Head entry is a combinational read.
    always_comb begin
        valid = (cnt != '0);
        head  = mem[rd];
        count = cnt;
    end

endmodule

// File: rtl/fetch_queue.sv
// Fetch front-end: issues PC pairs to the cache, collects hits in program
// order into inst_fifo, re-issues misses and handles branch redirects.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH    = 8,
    parameter addr_t       RESET_PC = '0
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  rdy,
    input  logic  redirect,
    input  addr_t redirect_pc,
    fetch_queue_if.master bus
);

    localparam int unsigned AW = $clog2(DEPTH);

    localparam logic [0:0] ST_ISSUE = 1'b0;
    localparam logic [0:0] ST_WAIT  = 1'b1;

    logic [0:0]  state;
    addr_t       pc;
    logic        issue;
    logic        take;
    logic        push0;
    logic        push1;
    logic [1:0]  npush;
    logic [AW:0] count;
    logic [AW:0] free;
    logic        valid;
    fq_entry_t   head;
    fq_entry_t   din0;
    fq_entry_t   din1;

    // Issue decision and response acceptance, all from registered state.
    always_comb begin
        free  = (AW+1)'(DEPTH) - count;
        issue = !rst && rdy && !redirect && (state == ST_ISSUE)
                && (free >= (AW+1)'(2)) && (pc != NULL_PTR);
        take  = (state == ST_WAIT) && rdy && !redirect && !rst;
        // A port-x miss drops the whole pair so program order is kept.
        push0 = take && bus.hitx;
        push1 = push0 && bus.hity;
        npush = 2'(push0) + 2'(push1);
        din0  = '{pc: pc, inst: bus.instx};
        din1  = '{pc: advance(pc, 2'd1), inst: bus.insty};
    end

    // Lookup and queue outputs; idle lookup ports show NULL_PTR.
    always_comb begin
        bus.en_rx   = issue;
        bus.en_ry   = issue;
        bus.pcx     = issue ? pc : NULL_PTR;
        bus.pcy     = issue ? advance(pc, 2'd1) : NULL_PTR;
        bus.q_valid = valid;
        bus.q_inst  = valid ? head.inst : ZERO;
        bus.q_pc    = valid ? head.pc : ZERO;
    end

    // FSM and fetch PC: reset, then redirect, then normal progress under rdy.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_ISSUE;
            pc    <= RESET_PC;
        end else if (redirect) begin
            state <= ST_ISSUE;
            pc    <= redirect_pc & ~addr_t'(3);
        end else if (rdy) begin
            case (state)
                ST_ISSUE: if (issue) state <= ST_WAIT;
                ST_WAIT: begin
                    pc    <= advance(pc, npush);
                    state <= ST_ISSUE;
                end
                default: state <= ST_ISSUE;
            endcase
        end
    end

    inst_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .en    (rdy),
        .clr   (redirect),
        .push0 (push0),
        .push1 (push1),
        .din0  (din0),
        .din1  (din1),
        .pop   (bus.q_pop),
        .valid (valid),
        .head  (head),
        .count (count)
    );

endmodule
